// File: rtl/hex_display_pkg.sv
// Shared constants and helpers for the paged hex 7-segment display.
// Segment codes are active-low, bit order gfedcba.
package hex_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) r = r + 1;
        return r;
    endfunction

    // Counter/index width that never collapses to zero bits.
    function automatic int unsigned min1_width(input int unsigned n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hex_page_display_if.sv
// Data/control bundle between a debug source and the paged hex display.
interface hex_page_display_if #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned NUM_PAGES  = 4
);
    localparam int unsigned PW = hex_display_pkg::min1_width(NUM_PAGES);

    logic [NUM_PAGES*NUM_DIGITS*4-1:0] data_in;
    logic [PW-1:0]                     page_sel;
    logic                              auto_mode;
    logic                              hold;
    logic                              blank_lz;
    logic                              blink_en;
    logic [NUM_DIGITS*7-1:0]           seg_out;
    logic [PW-1:0]                     page_idx;

    modport master (
        output data_in, page_sel, auto_mode, hold, blank_lz, blink_en,
        input  seg_out, page_idx
    );

    modport slave (
        input  data_in, page_sel, auto_mode, hold, blank_lz, blink_en,
        output seg_out, page_idx
    );
endinterface

// File: rtl/hex_digit_decode.sv
// One hex nibble to an active-low 7-segment pattern, with forced blank.
module hex_digit_decode
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);
    always_comb begin
        seg = blank ? SEG_BLANK : hex_to_seg(nibble);
    end
endmodule

// File: rtl/hex_page_display.sv
// Paged hex display: page select/rotation, snapshot, leading-zero blanking,
// blink and registered active-low segment outputs.
module hex_page_display
    import hex_display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned NUM_PAGES    = 4,
    parameter int unsigned DWELL_CYCLES = 50000000,
    parameter int unsigned BLINK_CYCLES = 12500000
) (
    input logic               clock,
    input logic               reset,
    hex_page_display_if.slave bus
);
    localparam int unsigned PW    = min1_width(NUM_PAGES);
    localparam int unsigned DW    = min1_width(DWELL_CYCLES);
    localparam int unsigned BW    = min1_width(BLINK_CYCLES);
    localparam int unsigned SLICE = NUM_DIGITS * 4;

    localparam logic [PW-1:0] PAGE_LAST  = PW'(NUM_PAGES - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    logic [PW-1:0]           page_q, page_d;
    logic [DW-1:0]           dwell_q, dwell_d;
    logic [BW-1:0]           blink_cnt_q, blink_cnt_d;
    logic                    phase_q, phase_d;
    logic [SLICE-1:0]        snap_q, snap_d;
    logic [NUM_DIGITS*7-1:0] seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    zero_run;

    // Page index and the snapshot always load on the same edge so they match.
    always_comb begin
        page_d  = page_q;
        dwell_d = dwell_q;
        snap_d  = snap_q;
        if (!bus.hold) begin
            if (bus.auto_mode && NUM_PAGES > 1) begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    page_d  = (page_q == PAGE_LAST) ? '0 : page_q + 1'b1;
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end else begin
                dwell_d = '0;
                page_d  = (bus.page_sel > PAGE_LAST) ? PAGE_LAST : bus.page_sel;
            end
            for (int unsigned p = 0; p < NUM_PAGES; p++) begin
                if (page_d == PW'(p)) snap_d = bus.data_in[p*SLICE +: SLICE];
            end
        end
    end

    always_comb begin
        blink_cnt_d = '0;
        phase_d     = 1'b1;
        if (bus.blink_en) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                phase_d     = !phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
                phase_d     = phase_q;
            end
        end
    end

    // Walk from the top digit down; digit 0 always shows so zero reads "0".
    always_comb begin
        blank    = '0;
        zero_run = 1'b1;
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            zero_run = zero_run && (snap_q[d*4 +: 4] == 4'h0);
            blank[d] = !phase_q || (bus.blank_lz && zero_run && d != 0);
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        hex_digit_decode u_dec (
            .nibble(snap_q[g*4 +: 4]),
            .blank (blank[g]),
            .seg   (seg_d[g*7 +: 7])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            page_q      <= '0;
            dwell_q     <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
            snap_q      <= '0;
            seg_q       <= '1;
        end else begin
            page_q      <= page_d;
            dwell_q     <= dwell_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            snap_q      <= snap_d;
            seg_q       <= seg_d;
        end
    end

    assign bus.seg_out  = seg_q;
    assign bus.page_idx = page_q;
endmodule

// File: tb/tb_hex_page_display.sv
// Scoreboard bench for hex_page_display: expectations are queued with a due
// cycle when stimulus is applied and compared on the falling edge.
module tb_hex_page_display;
    localparam int unsigned ND = 4;
    localparam int unsigned NP = 3;
    localparam int unsigned DW = 4;
    localparam int unsigned BL = 3;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    hex_page_display_if #(.NUM_DIGITS(ND), .NUM_PAGES(NP)) bus ();

    hex_page_display #(
        .NUM_DIGITS  (ND),
        .NUM_PAGES   (NP),
        .DWELL_CYCLES(DW),
        .BLINK_CYCLES(BL)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        int          due;
        bit          is_seg;
        logic [27:0] val;
        logic [63:0] tag;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    localparam logic [27:0] ALL_OFF = 28'hFFFFFFF;

    task automatic check_val(input logic [63:0] tag, input logic [27:0] got,
                             input logic [27:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %0s at cycle %0d: got=%h want=%h", tag, cyc, got, exp);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                if (sb[i].is_seg) check_val(sb[i].tag, bus.seg_out, sb[i].val);
                else check_val(sb[i].tag, 28'(bus.page_idx), sb[i].val);
                sb.delete(i);
            end
        end
    end

    function automatic logic [27:0] d4(input logic [6:0] a, input logic [6:0] b,
                                       input logic [6:0] c, input logic [6:0] d);
        return {a, b, c, d};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic want_seg(input logic [63:0] tag, input int dly, input logic [27:0] v);
        sb.push_back('{due: cyc + dly, is_seg: 1'b1, val: v, tag: tag});
    endtask

    task automatic want_pg(input logic [63:0] tag, input int dly, input int pg);
        sb.push_back('{due: cyc + dly, is_seg: 1'b0, val: 28'(pg), tag: tag});
    endtask

    task automatic set_page(input int p, input logic [15:0] v);
        bus.data_in[p*16 +: 16] = v;
    endtask

    initial begin
        logic [27:0] v1234;
        v1234 = d4(7'h79, 7'h24, 7'h30, 7'h19);

        reset         = 1'b1;
        bus.data_in   = '0;
        bus.page_sel  = '0;
        bus.auto_mode = 1'b0;
        bus.hold      = 1'b0;
        bus.blank_lz  = 1'b0;
        bus.blink_en  = 1'b0;
        set_page(0, 16'h1234);
        tick(1);
        want_seg("rst_seg", 1, ALL_OFF);
        want_pg("rst_pg", 1, 0);
        tick(1);
        reset = 1'b0;
        want_seg("boot_seg", 2, v1234);
        want_pg("boot_pg", 2, 0);
        tick(3);

        // Manual select and clamp of an out-of-range page_sel.
        set_page(2, 16'hABCD);
        bus.page_sel = 2'd2;
        want_seg("man_seg", 2, d4(7'h08, 7'h03, 7'h46, 7'h21));
        want_pg("man_pg", 2, 2);
        tick(2);
        bus.page_sel = 2'd3;
        want_pg("clamp_pg", 2, 2);
        want_seg("clamp_sg", 2, d4(7'h08, 7'h03, 7'h46, 7'h21));
        tick(2);

        // Auto rotation from page 0, then a 6-cycle hold right after a page change.
        set_page(0, 16'h0001);
        set_page(1, 16'h0002);
        set_page(2, 16'h0003);
        bus.page_sel = 2'd0;
        tick(3);
        bus.auto_mode = 1'b1;
        for (int k = 1; k <= 3; k++) want_pg("auto_p0", k, 0);
        want_pg("auto_p1", 4, 1);
        want_seg("auto_s1", 5, d4(7'h40, 7'h40, 7'h40, 7'h24));
        want_pg("auto_p2", 8, 2);
        want_seg("auto_s2", 9, d4(7'h40, 7'h40, 7'h40, 7'h30));
        want_pg("auto_wrp", 12, 0);
        tick(12);
        bus.hold = 1'b1;
        set_page(0, 16'h0009);
        for (int k = 1; k <= 6; k++) begin
            want_pg("hold_pg", k, 0);
            want_seg("hold_seg", k, d4(7'h40, 7'h40, 7'h40, 7'h79));
        end
        tick(6);
        bus.hold = 1'b0;
        set_page(0, 16'h0001);
        for (int k = 1; k <= 3; k++) want_pg("rel_p0", k, 0);
        want_pg("rel_p1", 4, 1);
        tick(5);

        // Leading-zero blanking.
        bus.auto_mode = 1'b0;
        bus.page_sel  = 2'd0;
        bus.blank_lz  = 1'b1;
        set_page(0, 16'h0050);
        want_seg("lz_0050", 2, d4(7'h7F, 7'h7F, 7'h12, 7'h40));
        tick(2);
        set_page(0, 16'h0000);
        want_seg("lz_0000", 2, d4(7'h7F, 7'h7F, 7'h7F, 7'h40));
        tick(2);
        set_page(0, 16'h1000);
        want_seg("lz_1000", 2, d4(7'h79, 7'h40, 7'h40, 7'h40));
        tick(2);

        // Blink with 3-cycle half period, then reset during the off phase.
        bus.blank_lz = 1'b0;
        set_page(0, 16'h1234);
        tick(3);
        bus.blink_en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            if ((k >= 4 && k <= 6) || k == 10) want_seg("blk_off", k, ALL_OFF);
            else want_seg("blk_on", k, v1234);
        end
        tick(10);
        reset        = 1'b1;
        bus.blink_en = 1'b0;
        want_seg("rst2_seg", 1, ALL_OFF);
        want_pg("rst2_pg", 1, 0);
        tick(1);
        reset = 1'b0;
        want_seg("post_rst", 2, v1234);
        want_seg("steady", 3, v1234);
        tick(4);

        if (sb.size() != 0) begin
            foreach (sb[i]) begin
                total++;
                bad++;
                $display("FAIL unchecked %0s due=%0d", sb[i].tag, sb[i].due);
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hex_page_display.md
Name: hex_page_display

Overview:
- Parametrised multi-digit 7-segment display controller for board debug output (processor registers, PC, memory data).
- Holds NUM_PAGES pages of NUM_DIGITS hex nibbles each.
- Selects one page manually or auto-rotates through the pages on a dwell timer.
- Applies optional leading-zero blanking, freeze and blink, and drives registered active-low segment outputs.

Parameters:
- NUM_DIGITS, 8, number of 7-segment digits (1..16); digit 0 is least significant.
- NUM_PAGES, 4, number of selectable data pages (1..16).
- DWELL_CYCLES, 50000000, clock cycles each page is shown in auto mode (>=1).
- BLINK_CYCLES, 12500000, half-period of blink in clock cycles (>=1).
- PW, derived max(1, clog2(NUM_PAGES)), page index width.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- data_in  in  NUM_PAGES*NUM_DIGITS*4  page p occupies bits [p*NUM_DIGITS*4 +: NUM_DIGITS*4]
- page_sel  in  PW  manual page index
- auto_mode  in  1  1 = auto-rotate pages, 0 = manual
- hold  in  1  1 = freeze displayed nibbles and page
- blank_lz  in  1  1 = blank leading zero digits
- blink_en  in  1  1 = flash the whole display
- seg_out  out  NUM_DIGITS*7  active-low segments, digit d at [d*7 +: 7], bit order gfedcba
- page_idx  out  PW  page currently displayed

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- Reset values:
  - seg_out = all ones (blank).
  - page_idx = 0.
  - Dwell counter = 0.
  - Blink counter = 0; blink phase = on.
  - Snapshot register = 0.
- Page selection, manual (auto_mode=0):
  - page_idx <= page_sel each cycle.
  - page_sel >= NUM_PAGES: page_idx <= NUM_PAGES-1 (clamped).
- Page selection, auto (auto_mode=1):
  - Dwell counter increments each cycle.
  - At DWELL_CYCLES-1: counter <= 0 and page_idx <= page_idx+1; NUM_PAGES-1 wraps to 0.
- Mode changes:
  - Manual->auto: rotation starts from the current page_idx with the dwell counter cleared.
  - Auto->manual: page_idx follows page_sel on the next edge; dwell counter cleared.
- Snapshot:
  - hold=0: snapshot <= slice of data_in for the page being loaded into page_idx this cycle. Snapshot and page_idx always match.
  - hold=1: snapshot, page_idx and dwell counter are all frozen. Blink keeps running.
- Blank-mask rule: with blank_lz=1, digit d is blanked when it and every digit above it are zero. Digit 0 is never blanked, so value 0 shows a single "0".
- Blink:
  - Blink counter runs whenever blink_en=1 and toggles the phase every BLINK_CYCLES cycles.
  - Off phase: all digits are blanked.
  - blink_en=0: counter cleared, phase forced on.
- Output: seg_out <= decode(snapshot) with blank digits forced to 7'h7F.
- Latency: seg_out reflects the snapshot one cycle after it loads, i.e. 2 cycles from data_in/page_sel to seg_out.
- Decode table (active-low):
  - 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
  - 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E
- Simultaneous events:
  - reset overrides everything.
  - hold overrides auto advance and page_sel changes.
  - A dwell expiry in the same cycle hold rises is discarded.
- Reset mid-rotation or mid-blink: returns to page 0, output blank for one cycle, then normal operation.
- NUM_PAGES=1: page_idx is constant 0 and auto mode has no effect.

Decomposition:
- Package hex_display_pkg:
  - SEG_BLANK = 7'h7F.
  - Localparams SEG_0..SEG_F.
  - Function hex_to_seg(4-bit) -> 7-bit.
  - Helper clog2.
- Sub-module hex_digit_decode: one 4-bit nibble plus blank -> 7-bit active-low. Combinational; instantiated NUM_DIGITS times via generate.
- Top holds the page FSM, counters, snapshot and output registers.

Test Plan (NUM_DIGITS=4, NUM_PAGES=3, DWELL_CYCLES=4, BLINK_CYCLES=3 unless noted):
- Reset with data_in page0=16'h1234 -> seg_out=all ones at first edge after reset; 2 cycles after release seg_out digits 3..0 = 79,24,30,19; page_idx=0.
- Manual: page_sel=2 with page2=16'hABCD -> seg_out = 08,03,46,21 after 2 cycles; page_sel=3 -> page_idx clamps to 2.
- Auto with pages 16'h0001/16'h0002/16'h0003 -> page_idx steps 0,1,2,0 every 4 cycles. hold=1 for 6 cycles freezes page_idx and seg_out. Dropping hold resumes with a full 4-cycle dwell.
- blank_lz=1:
  - 16'h0050 -> digits 3..2 = 7F, digits 1..0 = 12,40.
  - 16'h0000 -> 7F,7F,7F,40.
  - 16'h1000 -> no blanking.
- blink_en=1 on 16'h1234 -> seg_out alternates between value and all-ones every 3 cycles. Reset asserted during the off phase -> blank, then steady value 2 cycles after release with blink_en=0.
